// File: rtl/sc_timer_nb.sv
// ----------------------------------------------------------------------------
// sc_timer_nb -- parametrised synchronous timer/counter
//
// WIDTH-bit up/down counter with a programmable terminal value, parallel
// load, preset, and one-shot or periodic operation. A two-state run/halt
// machine freezes the count after a one-shot terminal step. The
// combinational terminal-count output tc is meant to be wired to the next
// stage's cten when stages are cascaded.
//
// Optional build macro: SC_PRESCALE_EN
//   When defined, an internal PRESC_W-bit prescaler divides the count
//   enable by (psc + 1) and the psc port is present. When undefined there is
//   no prescaler and no psc port, and the counter may step on every cycle.
//
// Parameters:
//   WIDTH    counter width in bits (2..32)
//   PRESC_W  prescaler width (used only with SC_PRESCALE_EN)
//
// Ports:
//   clk      in   rising-edge clock
//   clr      in   synchronous active-low reset
//   prs      in   synchronous active-low preset (out <= max_val)
//   cten     in   count enable
//   up       in   direction: 1 = up, 0 = down
//   ld       in   synchronous parallel load strobe
//   din      in   load value
//   max_val  in   terminal value counting up / reload value counting down
//   oneshot  in   1 = halt at terminal, 0 = periodic wrap
//   psc      in   prescale divisor minus 1 (SC_PRESCALE_EN only)
//   out      out  current count (registered)
//   tc       out  terminal count (combinational)
//   done     out  sticky one-shot completion flag (registered)
// ----------------------------------------------------------------------------
module sc_timer_nb #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned PRESC_W = 4
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               prs,
    input  logic               cten,
    input  logic               up,
    input  logic               ld,
    input  logic [WIDTH-1:0]   din,
    input  logic [WIDTH-1:0]   max_val,
    input  logic               oneshot,
`ifdef SC_PRESCALE_EN
    input  logic [PRESC_W-1:0] psc,
`endif
    output logic [WIDTH-1:0]   out,
    output logic               tc,
    output logic               done
);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   out_q,   out_d;
    logic               done_q,  done_d;

    logic               tick;
    logic               step;
    logic               terminal;

`ifdef SC_PRESCALE_EN
    logic [PRESC_W-1:0] presc_q, presc_d;

    // The step fires on the cycle the prescaler sits at psc; the same edge
    // returns the prescaler to zero.
    assign tick = (presc_q == psc);
`else
    // No prescaler is built; this comparison is constant 1.
    assign tick = (PRESC_W != 0);
`endif

    // Counting up, anything at or above max_val is terminal so that a load
    // beyond the terminal value still wraps instead of running to 2^WIDTH.
    assign terminal = up ? (out_q >= max_val) : (out_q == '0);
    assign step     = (state_q == RUN) && cten && tick;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of its inputs.
    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q <= RUN;
            out_q   <= '0;
            done_q  <= 1'b0;
`ifdef SC_PRESCALE_EN
            presc_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            done_q  <= done_d;
`ifdef SC_PRESCALE_EN
            presc_q <= presc_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic: prs > ld > count step (clr handled in the register)
    // ------------------------------------------------------------------
    // NOTE: every signal driven here gets a hold default first, which keeps
    // the block purely combinational with no inferred latches.
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        done_d  = done_q;
`ifdef SC_PRESCALE_EN
        presc_d = presc_q;
`endif

        if (!prs) begin
            out_d   = max_val;
            state_d = RUN;
            done_d  = 1'b0;
`ifdef SC_PRESCALE_EN
            presc_d = '0;
`endif
        end else if (ld) begin
            // A load consumes the cycle: no count step even with cten=1.
            out_d   = din;
            state_d = RUN;
            done_d  = 1'b0;
`ifdef SC_PRESCALE_EN
            presc_d = '0;
`endif
        end else begin
`ifdef SC_PRESCALE_EN
            if ((state_q == RUN) && cten) begin
                presc_d = tick ? '0 : presc_q + PRESC_W'(1);
            end
`endif
            if (step) begin
                if (!terminal) begin
                    out_d = up ? out_q + WIDTH'(1) : out_q - WIDTH'(1);
                end else if (!oneshot) begin
                    out_d = up ? '0 : max_val;
                end else begin
                    // One-shot terminal: count freezes, flag sticks until
                    // the next ld/prs/clr.
                    state_d = HALT;
                    done_d  = 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // tc is zero-latency so a cascaded stage steps on the same edge; the
    // clr term forces it low while the block is held in reset.
    always_comb begin
        tc   = step && terminal && clr;
        out  = out_q;
        done = done_q;
    end

endmodule

// File: tb/tb_sc_timer_nb.sv
// ----------------------------------------------------------------------------
// tb_sc_timer_nb -- directed self-checking bench for sc_timer_nb (WIDTH=8).
// Inputs change 1 ns after the rising edge; out/done are checked after the
// edge and tc is checked with the new inputs settled, before the next edge.
// ----------------------------------------------------------------------------
module tb_sc_timer_nb;

    localparam int unsigned WIDTH   = 8;
    localparam int unsigned PRESC_W = 4;

    logic               clk = 1'b0;
    logic               clr;
    logic               prs;
    logic               cten;
    logic               up;
    logic               ld;
    logic [WIDTH-1:0]   din;
    logic [WIDTH-1:0]   max_val;
    logic               oneshot;
`ifdef SC_PRESCALE_EN
    logic [PRESC_W-1:0] psc;
`endif
    logic [WIDTH-1:0]   out;
    logic               tc;
    logic               done;

    int total = 0;
    int bad   = 0;

    sc_timer_nb #(
        .WIDTH   (WIDTH),
        .PRESC_W (PRESC_W)
    ) dut (
        .clk     (clk),
        .clr     (clr),
        .prs     (prs),
        .cten    (cten),
        .up      (up),
        .ld      (ld),
        .din     (din),
        .max_val (max_val),
        .oneshot (oneshot),
`ifdef SC_PRESCALE_EN
        .psc     (psc),
`endif
        .out     (out),
        .tc      (tc),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick_edge();
        @(posedge clk);
        #1;
    endtask

    // Check the pre-edge count and tc, then advance one clock.
    task automatic cyc(input string tag, input logic [7:0] exp_out, input logic exp_tc);
        #1;
        check({tag, ".out"}, 32'(out), 32'(exp_out));
        check({tag, ".tc"},  32'(tc),   32'(exp_tc));
        tick_edge();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // ---------------- reset ----------------
        clr = 1'b0; prs = 1'b1; ld = 1'b1; cten = 1'b1; up = 1'b1;
        din = 8'h33; max_val = 8'h05; oneshot = 1'b0;
`ifdef SC_PRESCALE_EN
        psc = '0;
`endif
        tick_edge();
        tick_edge();
        check("rst.out",  32'(out),  32'h00);
        check("rst.tc",   32'(tc),   32'h0);
        check("rst.done", 32'(done), 32'h0);

        // ---------------- up periodic, max 5 ----------------
        clr = 1'b1; ld = 1'b0;
        cyc("up0", 8'h00, 1'b0);
        cyc("up1", 8'h01, 1'b0);
        cyc("up2", 8'h02, 1'b0);
        cyc("up3", 8'h03, 1'b0);
        cyc("up4", 8'h04, 1'b0);
        cyc("up5", 8'h05, 1'b1);
        cyc("upw", 8'h00, 1'b0);
        check("up.after", 32'(out), 32'h01);

        // ---------------- down periodic, reload 9 ----------------
        ld = 1'b1; din = 8'h02; up = 1'b0; max_val = 8'h09;
        tick_edge();
        ld = 1'b0;
        cyc("dn2", 8'h02, 1'b0);
        cyc("dn1", 8'h01, 1'b0);
        cyc("dn0", 8'h00, 1'b1);
        cyc("dn9", 8'h09, 1'b0);
        cten = 1'b0;
        cyc("hold0", 8'h08, 1'b0);
        cyc("hold1", 8'h08, 1'b0);
        cyc("hold2", 8'h08, 1'b0);
        check("hold.out", 32'(out), 32'h08);

        // ---------------- one-shot up, max 3 ----------------
        cten = 1'b1; ld = 1'b1; din = 8'h00; up = 1'b1; max_val = 8'h03; oneshot = 1'b1;
        tick_edge();
        ld = 1'b0;
        cyc("os0", 8'h00, 1'b0);
        cyc("os1", 8'h01, 1'b0);
        cyc("os2", 8'h02, 1'b0);
        check("os.done_pre", 32'(done), 32'h0);
        cyc("os3", 8'h03, 1'b1);
        check("os.done", 32'(done), 32'h1);
        cyc("os.halt0", 8'h03, 1'b0);
        cyc("os.halt1", 8'h03, 1'b0);
        check("os.halt_out",  32'(out),  32'h03);
        check("os.halt_done", 32'(done), 32'h1);
        ld = 1'b1; din = 8'h00;
        tick_edge();
        check("os.ld_done", 32'(done), 32'h0);
        check("os.ld_out",  32'(out),  32'h00);
        ld = 1'b0;
        tick_edge();
        check("os.resume", 32'(out), 32'h01);

        // ---------------- priority ----------------
        clr = 1'b0; prs = 1'b0; ld = 1'b1; din = 8'h44;
        #1;
        check("pri.tc_in_clr", 32'(tc), 32'h0);
        tick_edge();
        check("pri.clr", 32'(out), 32'h00);
        clr = 1'b1; max_val = 8'h7F;
        tick_edge();
        check("pri.prs", 32'(out), 32'h7F);
        prs = 1'b1;
        tick_edge();
        check("pri.ld", 32'(out), 32'h44);
        ld = 1'b0;
        tick_edge();
        check("pri.run", 32'(out), 32'h45);

        // ---------------- out-of-range load ----------------
        oneshot = 1'b0; max_val = 8'h10; ld = 1'b1; din = 8'hF0;
        tick_edge();
        ld = 1'b0;
        cyc("oor", 8'hF0, 1'b1);
        check("oor.wrap", 32'(out), 32'h00);

        // ---------------- max_val = 0 ----------------
        max_val = 8'h00;
        cyc("mz.up", 8'h00, 1'b1);
        up = 1'b0;
        cyc("mz.dn", 8'h00, 1'b1);
        check("mz.out", 32'(out), 32'h00);
        cten = 1'b0;
        #1;
        check("mz.tc_noen", 32'(tc), 32'h0);

`ifdef SC_PRESCALE_EN
        // ---------------- prescaler, psc = 2 ----------------
        psc = 4'd2; up = 1'b1; max_val = 8'hFF; oneshot = 1'b0;
        ld = 1'b1; din = 8'h00;
        tick_edge();
        ld = 1'b0; cten = 1'b1;
        tick_edge();
        check("ps.e1", 32'(out), 32'h00);
        tick_edge();
        check("ps.e2", 32'(out), 32'h00);
        tick_edge();
        check("ps.e3", 32'(out), 32'h01);
        cten = 1'b0;
        tick_edge();
        tick_edge();
        check("ps.gap", 32'(out), 32'h01);
        cten = 1'b1;
        tick_edge();
        tick_edge();
        check("ps.g2", 32'(out), 32'h01);
        tick_edge();
        check("ps.g3", 32'(out), 32'h02);
        tick_edge();
        ld = 1'b1; din = 8'h10;
        tick_edge();
        ld = 1'b0;
        tick_edge();
        tick_edge();
        check("ps.ld2", 32'(out), 32'h10);
        tick_edge();
        check("ps.ld3", 32'(out), 32'h11);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
